wishbone_primary_port: RTL

// Wishbone primary (initiator) that turns a core-side load/store request into one classic Wishbone cycle.

---
 rtl/wishbone_pkg.sv | 53 +++++
 rtl/wishbone_if.sv | 28 ++
 rtl/wishbone_primary_port.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/wishbone_pkg.sv
// Shared Wishbone definitions for the primary port and its bus interface.
// Holds the bus widths, the access-size encoding, and the helpers that turn
// an access size into byte selects and a raw read word into an extended load.
package wishbone_pkg;

   localparam int WB_AW = 32;
   localparam int WB_DW = 32;
   localparam int WB_SW = WB_DW / 8;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } access_size_t;

   // Lanes are address-relative, so selects are always low-aligned.
   // Encoding 3 is not a named size and falls through to a full word.
   function automatic logic [WB_SW-1:0] sel_from_size(input access_size_t size);
      logic [WB_SW-1:0] sel;
      case (size)
         SIZE_BYTE: sel = {{(WB_SW-1){1'b0}}, 1'b1};
         SIZE_HALF: sel = {{(WB_SW-2){1'b0}}, 2'b11};
         SIZE_WORD: sel = {WB_SW{1'b1}};
         default:   sel = {WB_SW{1'b1}};
      endcase
      return sel;
   endfunction

   // Expands each select bit into a byte-wide mask for the data lanes.
   function automatic logic [WB_DW-1:0] mask_from_sel(input logic [WB_SW-1:0] sel);
      logic [WB_DW-1:0] mask;
      for (int i = 0; i < WB_SW; i++) begin
         mask[8*i +: 8] = {8{sel[i]}};
      end
      return mask;
   endfunction

   // Fills the bytes above the access size with the sign bit of the top
   // selected byte, or with zero for unsigned loads.
   function automatic logic [WB_DW-1:0] extend_load(input logic [WB_DW-1:0] data,
                                                    input access_size_t      size,
                                                    input logic              is_unsigned);
      logic [WB_DW-1:0] result;
      case (size)
         SIZE_BYTE: result = {{(WB_DW-8){data[7] & ~is_unsigned}}, data[7:0]};
         SIZE_HALF: result = {{(WB_DW-16){data[15] & ~is_unsigned}}, data[15:0]};
         SIZE_WORD: result = data;
         default:   result = data;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/wishbone_if.sv
// Classic Wishbone bus bundle.
// Signals: cyc/stb (cycle and strobe), we (write enable), sel (byte selects),
// addr (byte address), dat_o_p (primary-to-secondary data),
// dat_i_p (secondary-to-primary data), ack (secondary acknowledge).
// Modports: primary (initiator side) and secondary (target side).
interface wishbone_if;
   import wishbone_pkg::*;

   logic             cyc;
   logic             stb;
   logic             we;
   logic [WB_SW-1:0] sel;
   logic [WB_AW-1:0] addr;
   logic [WB_DW-1:0] dat_o_p;
   logic [WB_DW-1:0] dat_i_p;
   logic             ack;

   modport primary (
      output cyc, stb, we, sel, addr, dat_o_p,
      input  dat_i_p, ack
   );

   modport secondary (
      input  cyc, stb, we, sel, addr, dat_o_p,
      output dat_i_p, ack
   );

endinterface

// File: rtl/wishbone_primary_port.sv
// Wishbone primary port: turns one core load/store request into one classic
// Wishbone cycle, with one transaction outstanding at a time.
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready     core request handshake
//   req_we/size/unsigned    store flag, access size, zero-extend flag for loads
//   req_addr/req_wdata      byte address and right-aligned store data
//   rsp_valid/rdata/err     one-cycle response pulse, extended load data, timeout flag
//   wb_if_p                 Wishbone primary modport
// All outputs come straight from flops. A cycle that sees no ack within
// TIMEOUT_CYCLES bus cycles is abandoned and answered with rsp_err.
module wishbone_primary_port
   import wishbone_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [WB_AW-1:0] req_addr,
   input  logic [WB_DW-1:0] req_wdata,
   output logic             rsp_valid,
   output logic [WB_DW-1:0] rsp_rdata,
   output logic             rsp_err,
   wishbone_if.primary      wb_if_p
);

   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]       state_q,     state_d;
   logic             cyc_q,       cyc_d;
   logic             we_q,        we_d;
   logic [WB_SW-1:0] sel_q,       sel_d;
   logic [WB_AW-1:0] addr_q,      addr_d;
   logic [WB_DW-1:0] dat_o_q,     dat_o_d;
   logic [TW-1:0]    timer_q,     timer_d;
   access_size_t     size_q,      size_d;
   logic             unsigned_q,  unsigned_d;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_err_q,   rsp_err_d;
   logic [WB_DW-1:0] rsp_rdata_q, rsp_rdata_d;

   logic [WB_SW-1:0] req_sel_s;

   // Byte selects for the incoming request, used when it is accepted.
   always_comb begin
      req_sel_s = sel_from_size(access_size_t'(req_size));
   end

   // Next-state logic for the transaction FSM, bus outputs and response.
   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      sel_d       = sel_q;
      addr_d      = addr_q;
      dat_o_d     = dat_o_q;
      timer_d     = timer_q;
      size_d      = size_q;
      unsigned_d  = unsigned_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = {WB_DW{1'b0}};

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d     = ST_BUS;
               cyc_d       = 1'b1;
               we_d        = req_we;
               sel_d       = req_sel_s;
               addr_d      = req_addr;
               // Loads put nothing on the write lanes; stores zero unselected bytes.
               if (req_we) begin
                  dat_o_d = req_wdata & mask_from_sel(req_sel_s);
               end else begin
                  dat_o_d = {WB_DW{1'b0}};
               end
               size_d      = access_size_t'(req_size);
               unsigned_d  = req_unsigned;
               timer_d     = {TW{1'b0}};
               req_ready_d = 1'b0;
            end else begin
               req_ready_d = 1'b1;
            end
         end

         ST_BUS: begin
            // ack is checked first so that an ack on the expiry cycle still wins.
            if (wb_if_p.ack || (timer_q == TIMER_LAST)) begin
               state_d     = ST_RESP;
               cyc_d       = 1'b0;
               we_d        = 1'b0;
               sel_d       = {WB_SW{1'b0}};
               addr_d      = {WB_AW{1'b0}};
               dat_o_d     = {WB_DW{1'b0}};
               rsp_valid_d = 1'b1;
               if (wb_if_p.ack) begin
                  rsp_err_d = 1'b0;
                  if (we_q) begin
                     rsp_rdata_d = {WB_DW{1'b0}};
                  end else begin
                     rsp_rdata_d = extend_load(wb_if_p.dat_i_p, size_q, unsigned_q);
                  end
               end else begin
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = {WB_DW{1'b0}};
               end
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end

         ST_RESP: begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
         end

         default: begin
            state_d     = ST_IDLE;
            cyc_d       = 1'b0;
            we_d        = 1'b0;
            sel_d       = {WB_SW{1'b0}};
            addr_d      = {WB_AW{1'b0}};
            dat_o_d     = {WB_DW{1'b0}};
            timer_d     = {TW{1'b0}};
            req_ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers; reset drops the bus immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= {WB_SW{1'b0}};
         addr_q      <= {WB_AW{1'b0}};
         dat_o_q     <= {WB_DW{1'b0}};
         timer_q     <= {TW{1'b0}};
         size_q      <= SIZE_BYTE;
         unsigned_q  <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= {WB_DW{1'b0}};
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         addr_q      <= addr_d;
         dat_o_q     <= dat_o_d;
         timer_q     <= timer_d;
         size_q      <= size_d;
         unsigned_q  <= unsigned_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign req_ready       = req_ready_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_err         = rsp_err_q;
   assign rsp_rdata       = rsp_rdata_q;
   assign wb_if_p.cyc     = cyc_q;
   assign wb_if_p.stb     = cyc_q;
   assign wb_if_p.we      = we_q;
   assign wb_if_p.sel     = sel_q;
   assign wb_if_p.addr    = addr_q;
   assign wb_if_p.dat_o_p = dat_o_q;

endmodule
